rtc_bus_arbiter: RTL and testbench

RTC_BUS_ARBITER -- requirements
Module: rtc_bus_arbiter

---
 rtl/rtc_bus_arbiter_if.sv | 32 +++
 rtl/rtc_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_rtc_bus_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_arbiter_if.sv
// rtc_bus_arbiter_if: channel request/grant and protocol-engine signals of the RTC bus arbiter.
interface rtc_bus_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_rw;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_grant;
    logic [NUM_CH-1:0]        ch_done;
    logic [DATA_W-1:0]        rd_data;
    logic [ADDR_W-1:0]        proto_addr;
    logic [DATA_W-1:0]        proto_wdata;
    logic                     proto_rw;
    logic                     proto_start;
    logic                     proto_done;
    logic [DATA_W-1:0]        proto_rdata;
    logic                     busy;
    logic                     timeout_err;

    modport slave (
        input  ch_req, ch_rw, ch_addr, ch_wdata, proto_done, proto_rdata,
        output ch_grant, ch_done, rd_data, proto_addr, proto_wdata, proto_rw, proto_start, busy, timeout_err
    );

    modport master (
        output ch_req, ch_rw, ch_addr, ch_wdata, proto_done, proto_rdata,
        input  ch_grant, ch_done, rd_data, proto_addr, proto_wdata, proto_rw, proto_start, busy, timeout_err
    );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: arbitrates NUM_CH channels onto one RTC protocol engine with a transfer watchdog.
// Fixed priority by default; define RTC_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module rtc_bus_arbiter #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int TO_CYC = 255
) (
    input  logic              clk,
    input  logic              Reset,
    rtc_bus_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NUM_CH);
    localparam int CW = $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NUM_CH-1:0] grant_q, grant_d, done_q, done_d;
    logic              start_q, start_d, rw_q, rw_d, terr_q, terr_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_sel;
    logic [DATA_W-1:0] wdata_q, wdata_d, wdata_sel, rd_q, rd_d;
    logic              rw_sel;
    logic [IW-1:0]     pick, idx;

`ifdef RTC_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] ptr_q;

    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr_q) + k) % NUM_CH);
            if (bus.ch_req[idx]) pick = idx;
        end
    end

    always_ff @(posedge clk)
        if (Reset)
            ptr_q <= '0;
        else if (state_q == IDLE && |bus.ch_req)
            ptr_q <= IW'((int'(pick) + 1) % NUM_CH);
`else
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = IW'(k);
            if (bus.ch_req[idx]) pick = idx;
        end
    end
`endif

    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        rw_sel    = 1'b0;
        for (int k = 0; k < NUM_CH; k++)
            if (IW'(k) == pick) begin
                addr_sel  = bus.ch_addr[k*ADDR_W +: ADDR_W];
                wdata_sel = bus.ch_wdata[k*DATA_W +: DATA_W];
                rw_sel    = bus.ch_rw[k];
            end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        done_d  = '0;
        start_d = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        rd_d    = rd_q;
        terr_d  = terr_q;
        case (state_q)
            IDLE: if (|bus.ch_req) begin
                state_d = XFER;
                cnt_d   = '0;
                grant_d = NUM_CH'(1) << pick;
                start_d = 1'b1;
                addr_d  = addr_sel;
                wdata_d = wdata_sel;
                rw_d    = rw_sel;
            end
            XFER: begin
                cnt_d = cnt_q + 1'b1;
                // A completion on the watchdog's last cycle still counts as success.
                if (bus.proto_done || cnt_q == CW'(TO_CYC)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    grant_d = '0;
                    done_d  = grant_q;
                    rd_d    = (bus.proto_done && !rw_q) ? bus.proto_rdata : rd_q;
                    terr_d  = terr_q | !bus.proto_done;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            rd_q    <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            start_q <= start_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            rd_q    <= rd_d;
            terr_q  <= terr_d;
        end

    assign bus.ch_grant    = grant_q;
    assign bus.ch_done     = done_q;
    assign bus.rd_data     = rd_q;
    assign bus.proto_addr  = addr_q;
    assign bus.proto_wdata = wdata_q;
    assign bus.proto_rw    = rw_q;
    assign bus.proto_start = start_q;
    assign bus.busy        = state_q == XFER;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb_rtc_bus_arbiter: randomized transfers checked against a transaction-level arbiter model.
module tb_rtc_bus_arbiter;
    localparam int N = 4, AW = 8, DW = 8, TO = 255;
    localparam int AT = N * AW, DT = N * DW;

    logic clk = 1'b0, Reset = 1'b1;
    int n_vec = 0, n_bad = 0, last = N - 1;
    logic [DW-1:0] exp_rd = '0;
    logic exp_terr = 1'b0;

    rtc_bus_arbiter_if #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) bus();
    rtc_bus_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .TO_CYC(TO)) dut (
        .clk(clk), .Reset(Reset), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Arbitration rule: next requester after the last winner, or lowest index.
    function automatic int pick(input logic [N-1:0] req);
`ifdef RTC_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) if (req[(last + k) % N]) return (last + k) % N;
`else
        for (int i = 0; i < N; i++) if (req[i]) return i;
`endif
        return -1;
    endfunction

    task automatic idle_chk(input string tag);
        chk({tag, ".busy"}, 64'(bus.busy), 64'(0));
        chk({tag, ".grant"}, 64'(bus.ch_grant), 64'(0));
        chk({tag, ".done"}, 64'(bus.ch_done), 64'(0));
        chk({tag, ".start"}, 64'(bus.proto_start), 64'(0));
        chk({tag, ".rd"}, 64'(bus.rd_data), 64'(exp_rd));
        chk({tag, ".terr"}, 64'(bus.timeout_err), 64'(exp_terr));
    endtask

    // lat = XFER cycle (from 0) on which proto_done pulses; negative means never.
    task automatic xfer(input logic [N-1:0] req, input logic [N-1:0] rw, input logic [AT-1:0] addr,
                        input logic [DT-1:0] wd, input int lat, input logic [DW-1:0] rdat, input bit mut);
        int w, endk;
        bit ok;
        bus.ch_req = req;
        bus.ch_rw = rw;
        bus.ch_addr = addr;
        bus.ch_wdata = wd;
        bus.proto_done = 1'b0;
        w = pick(req);
        @(posedge clk); #1;
        chk("grant", 64'(bus.ch_grant), 64'(1) << w);
        chk("start", 64'(bus.proto_start), 64'(1));
        chk("busy", 64'(bus.busy), 64'(1));
        chk("paddr", 64'(bus.proto_addr), 64'(addr[w*AW +: AW]));
        chk("pwdata", 64'(bus.proto_wdata), 64'(wd[w*DW +: DW]));
        chk("prw", 64'(bus.proto_rw), 64'(rw[w]));
        last = w;
        ok = lat >= 0 && lat <= TO;
        endk = ok ? lat : TO;
        if (mut) begin
            bus.ch_req = '0;
            bus.ch_rw = ~rw;
            bus.ch_addr = addr ^ {N{AW'(8'h32)}};
            bus.ch_wdata = ~wd;
        end
        for (int k = 0; k <= endk; k++) begin
            bus.proto_done = (k == lat);
            bus.proto_rdata = (k == lat) ? rdat : DW'($urandom);
            if (k == 1) chk("start.pulse", 64'(bus.proto_start), 64'(0));
            if (k == endk) begin
                chk("hold.grant", 64'(bus.ch_grant), 64'(1) << w);
                chk("hold.busy", 64'(bus.busy), 64'(1));
                chk("hold.paddr", 64'(bus.proto_addr), 64'(addr[w*AW +: AW]));
                chk("hold.done", 64'(bus.ch_done), 64'(0));
            end
            @(posedge clk); #1;
        end
        bus.proto_done = 1'($urandom_range(0, 1));
        if (ok && !rw[w]) exp_rd = rdat;
        if (!ok) exp_terr = 1'b1;
        chk("done", 64'(bus.ch_done), 64'(1) << w);
        chk("done.busy", 64'(bus.busy), 64'(0));
        chk("done.grant", 64'(bus.ch_grant), 64'(0));
        chk("rd_data", 64'(bus.rd_data), 64'(exp_rd));
        chk("timeout_err", 64'(bus.timeout_err), 64'(exp_terr));
        chk("done.paddr", 64'(bus.proto_addr), 64'(addr[w*AW +: AW]));
        @(posedge clk); #1;
        bus.proto_done = 1'b0;
        idle_chk("idle");
    endtask

    initial begin
        int r, lat;
        bus.ch_req = '0;
        bus.ch_rw = '0;
        bus.ch_addr = '0;
        bus.ch_wdata = '0;
        bus.proto_done = 1'b0;
        bus.proto_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        idle_chk("reset");
        chk("reset.paddr", 64'(bus.proto_addr), 64'(0));
        chk("reset.pwdata", 64'(bus.proto_wdata), 64'(0));
        chk("reset.prw", 64'(bus.proto_rw), 64'(0));
        Reset = 1'b0;

        xfer(4'b0110, 4'b0000, 32'h44332211, 32'hd4c3b2a1, 3, 8'h00, 1'b0);
        xfer(4'b0100, 4'b0000, 32'h00210000, 32'h0, 10, 8'h59, 1'b0);
        xfer(4'b0010, 4'b0010, 32'h00001000, 32'h00007700, 5, 8'hee, 1'b1);
        xfer(4'b0001, 4'b0000, 32'h000000aa, 32'h0, -1, 8'h00, 1'b0);
        xfer(4'b1000, 4'b0000, 32'hbb000000, 32'h0, TO, 8'h3c, 1'b0);
        xfer(4'b0100, 4'b0000, 32'h00cc0000, 32'h0, TO + 1, 8'h77, 1'b0);
        repeat (4) xfer(4'b1111, 4'b1010, 32'h40302010, 32'h04030201, 0, 8'h5a, 1'b0);

        repeat (120) begin
            r = $urandom_range(0, 19);
            lat = r < 16 ? int'($urandom_range(0, 12)) : r == 16 ? TO : r == 17 ? -1 : int'($urandom_range(TO - 2, TO));
            xfer(N'($urandom_range(1, 2**N - 1)), N'($urandom), AT'($urandom), DT'($urandom),
                 lat, DW'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                bus.ch_req = '0;
                repeat ($urandom_range(1, 3)) begin
                    bus.proto_done = 1'($urandom_range(0, 1));
                    bus.proto_rdata = DW'($urandom);
                    @(posedge clk); #1;
                    idle_chk("gap");
                end
                bus.proto_done = 1'b0;
            end
        end

        bus.ch_req = 4'b0100;
        bus.ch_addr = 32'h00990000;
        bus.ch_wdata = 32'h00880000;
        bus.ch_rw = 4'b0100;
        repeat (4) @(posedge clk);
        #1;
        chk("mid.busy", 64'(bus.busy), 64'(1));
        Reset = 1'b1;
        bus.ch_req = '0;
        @(posedge clk); #1;
        exp_rd = '0;
        exp_terr = 1'b0;
        last = N - 1;
        idle_chk("midreset");
        chk("midreset.paddr", 64'(bus.proto_addr), 64'(0));
        chk("midreset.pwdata", 64'(bus.proto_wdata), 64'(0));
        chk("midreset.prw", 64'(bus.proto_rw), 64'(0));
        Reset = 1'b0;
        @(posedge clk); #1;
        idle_chk("postreset");
        xfer(4'b1100, 4'b0000, 32'h12340000, 32'h0, 2, 8'h6b, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
